// File: rtl/log_shift_arbiter_if.sv
// Requester/response bundle for log_shift_arbiter: per-requester valid/ready/data/amt
// plus the single tagged response slot. "slave" is the arbiter side, "master" the clients.
interface log_shift_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 4
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*INPUT_WIDTH-1:0]  req_data;
  logic [NUM_REQ*WEIGHT_WIDTH-1:0] req_amt;
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [INPUT_WIDTH-1:0]          rsp_data;
  logic [ID_WIDTH-1:0]             rsp_id;
  logic                            busy;

  modport master (
    output req_valid, req_data, req_amt, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_amt, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/log_shift_arbiter.sv
// Round-robin arbiter sharing one logarithmic right shifter among NUM_REQ requesters,
// with a single registered response slot. Optional grant counters: LOG_SHIFT_ARB_STATS_EN.
module log_shift_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  log_shift_arbiter_if.slave      bus
`ifdef LOG_SHIFT_ARB_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [NUM_REQ*16-1:0]   stat_grant_cnt
`endif
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                  state_reg, state_next;
  logic [INPUT_WIDTH-1:0]  rsp_data_reg;
  logic [ID_WIDTH-1:0]     rsp_id_reg;
  logic [ID_WIDTH-1:0]     rr_ptr_reg;
  logic [ID_WIDTH-1:0]     rr_ptr_next;

  logic                    accept;
  logic                    grant;
  logic                    found;
  logic [ID_WIDTH-1:0]     gnt_idx;
  logic [ID_WIDTH-1:0]     cand;

  logic [INPUT_WIDTH-1:0]  sel_data;
  logic [WEIGHT_WIDTH-1:0] sel_amt;
  logic [INPUT_WIDTH-1:0]  stage [WEIGHT_WIDTH+1];

  genvar gi;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = (state_reg == EMPTY) || bus.rsp_ready;
    // rst_n gates grant so req_ready stays 0 while reset is held.
    grant      = accept && found && rst_n;
    case (state_reg)
      EMPTY:   if (grant) state_next = FULL;
      FULL:    if (bus.rsp_ready && !grant) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  assign rr_ptr_next = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = grant && (gnt_idx == ID_WIDTH'(gi));
    end
  endgenerate

  assign sel_data = bus.req_data[int'(gnt_idx)*INPUT_WIDTH +: INPUT_WIDTH];
  assign sel_amt  = bus.req_amt[int'(gnt_idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];

  // Stage gi shifts by 2**gi; stages at or beyond the data width simply clear.
  assign stage[0] = sel_data;
  generate
    for (gi = 0; gi < WEIGHT_WIDTH; gi++) begin : g_shift
      localparam int SH = 1 << gi;
      if (SH >= INPUT_WIDTH) begin : g_clr
        assign stage[gi+1] = sel_amt[gi] ? '0 : stage[gi];
      end else begin : g_sh
        assign stage[gi+1] = sel_amt[gi] ? (stage[gi] >> SH) : stage[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      rsp_data_reg <= '0;
      rsp_id_reg   <= '0;
      rr_ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        rsp_data_reg <= stage[WEIGHT_WIDTH];
        rsp_id_reg   <= gnt_idx;
        rr_ptr_reg   <= rr_ptr_next;
      end
    end
  end

  assign bus.rsp_valid = (state_reg == FULL);
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.busy      = bus.rsp_valid | (|bus.req_valid);

`ifdef LOG_SHIFT_ARB_STATS_EN
  // Clear wins over a coincident grant.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
      logic [15:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (stat_clr) begin
          cnt_reg <= '0;
        end else if (bus.req_ready[gi] && cnt_reg != 16'hFFFF) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign stat_grant_cnt[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif
endmodule

// File: tb/tb_log_shift_arbiter.sv
// Self-checking bench for log_shift_arbiter: directed steps plus randomized traffic
// against a round-robin / (data >> amt) reference model with per-ID scoreboards.
module tb_log_shift_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  log_shift_arbiter_if #(.NUM_REQ(N), .INPUT_WIDTH(W), .WEIGHT_WIDTH(AW)) bus ();

`ifdef LOG_SHIFT_ARB_STATS_EN
  logic            stat_clr = 1'b0;
  logic [N*16-1:0] stat_grant_cnt;
`endif

  log_shift_arbiter #(.NUM_REQ(N), .INPUT_WIDTH(W), .WEIGHT_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LOG_SHIFT_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_grant_cnt (stat_grant_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_id;
  int          m_ptr;
  logic [W-1:0] exp_q [N][$];
  int          grants [N];

  // Per-requester pending requests (random phase)
  bit          pend [N];
  logic [W-1:0] pdata [N];
  logic [AW-1:0] pamt [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [W-1:0] d, input logic [AW-1:0] a);
    bus.req_valid[i]         = v;
    bus.req_data[i*W +: W]   = d;
    bus.req_amt[i*AW +: AW]  = a;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_amt   = '0;
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) exp_q[i].delete();
  endtask

  task automatic do_reset(input bit valid_during);
    rst_n = 1'b0;
    clear_reqs();
    if (valid_during) bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rst.req_ready", bus.req_ready, '0);
    chk("rst.rsp_valid", bus.rsp_valid, 0);
    chk("rst.rsp_data", bus.rsp_data, 0);
    chk("rst.rsp_id", bus.rsp_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_reqs();
    model_reset();
    @(posedge clk); #1;
  endtask

  // One cycle: check outputs at the falling edge against the model, advance model,
  // return at rising edge + 1 with the granted index (or -1).
  task automatic tick(input string tag, output int g);
    bit acc;
    logic [N-1:0] er;
    int idx;
    logic [W-1:0] d;
    logic [AW-1:0] a;
    @(negedge clk);
    acc = !m_valid || bus.rsp_ready;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && bus.req_valid[idx]) g = idx;
    end
    if (!acc) g = -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk($sformatf("%s.req_ready", tag), bus.req_ready, er);
    chk($sformatf("%s.rsp_valid", tag), bus.rsp_valid, m_valid);
    chk($sformatf("%s.rsp_data", tag), bus.rsp_data, m_data);
    chk($sformatf("%s.rsp_id", tag), bus.rsp_id, m_id);
    chk($sformatf("%s.busy", tag), bus.busy, m_valid || (|bus.req_valid));
    if (m_valid && bus.rsp_ready) begin
      if (exp_q[m_id].size() == 0) chk($sformatf("%s.sb_empty", tag), 1, 0);
      else chk($sformatf("%s.sb_order", tag), bus.rsp_data, exp_q[m_id].pop_front());
    end
    if (g >= 0) begin
      d = bus.req_data[g*W +: W];
      a = bus.req_amt[g*AW +: AW];
      m_valid = 1;
      m_data  = d >> a;
      m_id    = g;
      m_ptr   = (g + 1) % N;
      exp_q[g].push_back(d >> a);
      grants[g]++;
    end else if (bus.rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clk); #1;
    $display("[TB] %s: grant=%0d rsp_valid=%0b rsp_id=%0d rsp_data=%04h", tag, g, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
  endtask

  task automatic single(input string tag, input logic [W-1:0] d, input logic [AW-1:0] a, input logic [W-1:0] exp);
    int g;
    set_req(0, 1, d, a);
    bus.rsp_ready = 1'b1;
    tick(tag, g);
    set_req(0, 0, '0, '0);
    chk($sformatf("%s.direct", tag), bus.rsp_data, exp);
  endtask

  initial begin
    int g;
    int cyc;
    bit done;
    clear_reqs();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) grants[i] = 0;

    do_reset(1);

    // 1. Single request
    set_req(0, 1, 16'hF0F0, 4'd4);
    bus.rsp_ready = 1'b1;
    tick("t1.req", g);
    chk("t1.grant", g, 0);
    set_req(0, 0, '0, '0);
    chk("t1.rsp_valid", bus.rsp_valid, 1);
    chk("t1.rsp_data", bus.rsp_data, 16'h0F0F);
    chk("t1.rsp_id", bus.rsp_id, 0);
    tick("t1.drain", g);

    // 2. All four continuously valid: strict rotation, no bubbles
    do_reset(0);
    for (int i = 0; i < N; i++) set_req(i, 1, W'(16'h1111 * (i + 1)), AW'(i));
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 2 * N; c++) begin
      tick("t2.rr", g);
      chk("t2.order", g, c % N);
      chk("t2.rsp_id", bus.rsp_id, c % N);
    end
    clear_reqs();
    tick("t2.drain", g);

    // 3. Backpressure with req1 pending
    do_reset(0);
    set_req(0, 1, 16'h00FF, 4'd1);
    bus.rsp_ready = 1'b0;
    tick("t3.fill", g);
    set_req(0, 0, '0, '0);
    set_req(1, 1, 16'hFFFF, 4'd8);
    for (int c = 0; c < 5; c++) begin
      tick("t3.hold", g);
      chk("t3.no_grant", g, -1);
      chk("t3.held_data", bus.rsp_data, 16'h007F);
    end
    bus.rsp_ready = 1'b1;
    tick("t3.release", g);
    chk("t3.grant1", g, 1);
    set_req(1, 0, '0, '0);
    chk("t3.new_data", bus.rsp_data, 16'h00FF);
    tick("t3.drain", g);

    // 4. Shift amount boundaries
    single("t4.amt0", 16'hABCD, 4'd0, 16'hABCD);
    single("t4.amt15a", 16'h8000, 4'd15, 16'h0001);
    single("t4.amt15b", 16'h7FFF, 4'd15, 16'h0000);
    tick("t4.drain", g);

    // 5. Reset while FULL under backpressure
    set_req(1, 1, 16'h1234, 4'd2);
    bus.rsp_ready = 1'b0;
    tick("t5.fill", g);
    set_req(1, 0, '0, '0);
    chk("t5.full", bus.rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("t5.async_clear", bus.rsp_valid, 0);
    do_reset(0);
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    tick("t5.after", g);
    chk("t5.first_grant", g, 0);
    clear_reqs();
    tick("t5.drain", g);

`ifdef LOG_SHIFT_ARB_STATS_EN
    // 6. Grant counters
    do_reset(0);
    bus.rsp_ready = 1'b1;
    set_req(2, 1, 16'h0F00, 4'd4);
    for (int c = 0; c < 10; c++) tick("t6.grant", g);
    set_req(2, 0, '0, '0);
    tick("t6.idle", g);
    chk("t6.cnt2", stat_grant_cnt[2*16 +: 16], 10);
    chk("t6.cnt0", stat_grant_cnt[0 +: 16], 0);
    set_req(2, 1, 16'h0F00, 4'd4);
    stat_clr = 1'b1;
    tick("t6.clr", g);
    stat_clr = 1'b0;
    set_req(2, 0, '0, '0);
    chk("t6.cleared", stat_grant_cnt, '0);
    tick("t6.drain", g);
`endif

    // Random traffic: 100 grants per requester
    do_reset(0);
    for (int i = 0; i < N; i++) begin grants[i] = 0; pend[i] = 0; end
    cyc = 0;
    done = 0;
    while (!done && cyc < 20000) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && grants[i] < 100 && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1;
          pdata[i] = W'($urandom);
          pamt[i]  = AW'($urandom);
        end
        set_req(i, pend[i], pend[i] ? pdata[i] : '0, pend[i] ? pamt[i] : '0);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick("rnd", g);
      if (g >= 0) pend[g] = 0;
      cyc++;
      done = 1;
      for (int i = 0; i < N; i++) if (grants[i] < 100) done = 0;
    end
    chk("rnd.completed", done, 1);
    clear_reqs();
    bus.rsp_ready = 1'b1;
    tick("rnd.drain0", g);
    tick("rnd.drain1", g);
    for (int i = 0; i < N; i++) chk($sformatf("rnd.sb_left%0d", i), exp_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
